// File: rtl/core_types_pkg.sv
// Shared core sizing constants and ALU op encodings, used by every execution pipeline.
package core_types_pkg;

  localparam int LOG_PR_COUNT       = 6;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 4'b0000;
  localparam alu_op_t ALU_SUB  = 4'b1000;
  localparam alu_op_t ALU_SLL  = 4'b0001;
  localparam alu_op_t ALU_SLT  = 4'b0010;
  localparam alu_op_t ALU_SLTU = 4'b0011;
  localparam alu_op_t ALU_XOR  = 4'b0100;
  localparam alu_op_t ALU_SRL  = 4'b0101;
  localparam alu_op_t ALU_SRA  = 4'b1101;
  localparam alu_op_t ALU_OR   = 4'b0110;
  localparam alu_op_t ALU_AND  = 4'b0111;

  // One operand slot in operand collect: value plus whether it has arrived.
  typedef struct packed {
    logic [31:0] val;
    logic        done;
  } operand_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU, zero latency; unknown op codes produce 0.
module alu
  import core_types_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = A + B;
      ALU_SUB:  result = A - B;
      ALU_SLL:  result = A << B[4:0];
      ALU_SLT:  result = {31'd0, $signed(A) < $signed(B)};
      ALU_SLTU: result = {31'd0, A < B};
      ALU_XOR:  result = A ^ B;
      ALU_SRL:  result = A >> B[4:0];
      ALU_SRA:  result = $signed(A) >>> B[4:0];
      ALU_OR:   result = A | B;
      ALU_AND:  result = A & B;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipeline.sv
// OC/EX/WB ALU pipeline: issue at N gives WB_valid at N+3 when operands are ready.
// WB_ready low stalls WB, then EX, then OC; bubbles collapse and issue_ready drops only when OC cannot move.
module alu_pipeline #(
  parameter int LOG_PR_COUNT   = core_types_pkg::LOG_PR_COUNT,
  parameter int PRF_BANK_COUNT = core_types_pkg::PRF_BANK_COUNT
) (
  input  logic                                          CLK,
  input  logic                                          RST,
  input  logic                                          issue_valid,
  output logic                                          issue_ready,
  input  logic [3:0]                                    issue_op,
  input  logic                                          issue_is_imm,
  input  logic [31:0]                                   issue_imm,
  input  logic                                          issue_A_unneeded,
  input  logic                                          issue_A_forward,
  input  logic [core_types_pkg::LOG_PRF_BANK_COUNT-1:0] issue_A_bank,
  input  logic                                          issue_B_forward,
  input  logic [core_types_pkg::LOG_PRF_BANK_COUNT-1:0] issue_B_bank,
  input  logic [LOG_PR_COUNT-1:0]                       issue_dest_PR,
  input  logic [PRF_BANK_COUNT-1:0][31:0]               WB_data_by_bank,
  input  logic                                          A_reg_read_valid,
  input  logic [31:0]                                   A_reg_read_data,
  input  logic                                          B_reg_read_valid,
  input  logic [31:0]                                   B_reg_read_data,
  output logic                                          WB_valid,
  output logic [31:0]                                   WB_data,
  output logic [LOG_PR_COUNT-1:0]                       WB_PR,
  input  logic                                          WB_ready
);

  import core_types_pkg::*;

  logic                    oc_v, ex_v, wb_v;
  alu_op_t                 oc_op, ex_op;
  operand_t                oc_a, oc_b, a_in, b_in;
  logic [LOG_PR_COUNT-1:0] oc_dest, ex_dest, wb_pr;
  logic [31:0]             ex_a, ex_b, ex_result, wb_data, a_val, b_val;
  logic                    a_resp, b_resp, operands_done;
  logic                    wb_adv, ex_adv, oc_adv, accept, issue_fire;

  always_comb begin
    // Read responses only count for an occupied OC slot still waiting on that operand.
    a_resp        = oc_v & ~oc_a.done & A_reg_read_valid;
    b_resp        = oc_v & ~oc_b.done & B_reg_read_valid;
    a_val         = oc_a.done ? oc_a.val : A_reg_read_data;
    b_val         = oc_b.done ? oc_b.val : B_reg_read_data;
    operands_done = (oc_a.done | a_resp) & (oc_b.done | b_resp);

    wb_adv     = ~wb_v | WB_ready;
    ex_adv     = ex_v & wb_adv;
    oc_adv     = oc_v & operands_done & (~ex_v | ex_adv);
    accept     = ~oc_v | oc_adv;
    issue_fire = issue_valid & accept;

    a_in = '{val: 32'd0, done: 1'b0};
    if (issue_A_unneeded)     a_in = '{val: 32'd0, done: 1'b1};
    else if (issue_A_forward) a_in = '{val: WB_data_by_bank[issue_A_bank], done: 1'b1};

    b_in = '{val: 32'd0, done: 1'b0};
    if (issue_is_imm)         b_in = '{val: issue_imm, done: 1'b1};
    else if (issue_B_forward) b_in = '{val: WB_data_by_bank[issue_B_bank], done: 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      oc_v    <= 1'b0;
      oc_op   <= '0;
      oc_a    <= '0;
      oc_b    <= '0;
      oc_dest <= '0;
      ex_v    <= 1'b0;
      ex_op   <= '0;
      ex_a    <= '0;
      ex_b    <= '0;
      ex_dest <= '0;
      wb_v    <= 1'b0;
      wb_data <= '0;
      wb_pr   <= '0;
    end else begin
      if (issue_fire) begin
        oc_v    <= 1'b1;
        oc_op   <= issue_op;
        oc_a    <= a_in;
        oc_b    <= b_in;
        oc_dest <= issue_dest_PR;
      end else if (oc_adv) begin
        oc_v <= 1'b0;
      end else begin
        if (a_resp) oc_a <= '{val: A_reg_read_data, done: 1'b1};
        if (b_resp) oc_b <= '{val: B_reg_read_data, done: 1'b1};
      end

      if (oc_adv) begin
        ex_v    <= 1'b1;
        ex_op   <= oc_op;
        ex_a    <= a_val;
        ex_b    <= b_val;
        ex_dest <= oc_dest;
      end else if (ex_adv) begin
        ex_v <= 1'b0;
      end

      if (wb_adv) begin
        wb_v <= ex_v;
        if (ex_v) begin
          wb_data <= ex_result;
          wb_pr   <= ex_dest;
        end
      end
    end
  end

  alu u_alu (
    .op     (ex_op),
    .A      (ex_a),
    .B      (ex_b),
    .result (ex_result)
  );

  // Outputs are forced to their idle values while RST is high, before the registers clear.
  assign issue_ready = RST | accept;
  assign WB_valid    = wb_v & ~RST;
  assign WB_data     = RST ? 32'd0 : wb_data;
  assign WB_PR       = RST ? '0 : wb_pr;

endmodule

// File: tb/tb_alu_pipeline.sv
// Scoreboard bench for alu_pipeline: directed latency/stall/reset cases plus randomised traffic.
module tb_alu_pipeline;
  import core_types_pkg::*;

  localparam int PRW = LOG_PR_COUNT;

  logic                   CLK = 1'b0;
  logic                   RST;
  logic                   issue_valid, issue_ready;
  logic [3:0]             issue_op;
  logic                   issue_is_imm;
  logic [31:0]            issue_imm;
  logic                   issue_A_unneeded, issue_A_forward;
  logic [1:0]             issue_A_bank;
  logic                   issue_B_forward;
  logic [1:0]             issue_B_bank;
  logic [PRW-1:0]         issue_dest_PR;
  logic [3:0][31:0]       WB_data_by_bank;
  logic                   A_reg_read_valid, B_reg_read_valid;
  logic [31:0]            A_reg_read_data, B_reg_read_data;
  logic                   WB_valid;
  logic [31:0]            WB_data;
  logic [PRW-1:0]         WB_PR;
  logic                   WB_ready;

  typedef struct {
    logic [31:0]    data;
    logic [PRW-1:0] pr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acc = 0;
  int   n_wb  = 0;
  bit   rand_done;

  always #5 CLK = ~CLK;

  alu_pipeline dut (
    .CLK              (CLK),
    .RST              (RST),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_op         (issue_op),
    .issue_is_imm     (issue_is_imm),
    .issue_imm        (issue_imm),
    .issue_A_unneeded (issue_A_unneeded),
    .issue_A_forward  (issue_A_forward),
    .issue_A_bank     (issue_A_bank),
    .issue_B_forward  (issue_B_forward),
    .issue_B_bank     (issue_B_bank),
    .issue_dest_PR    (issue_dest_PR),
    .WB_data_by_bank  (WB_data_by_bank),
    .A_reg_read_valid (A_reg_read_valid),
    .A_reg_read_data  (A_reg_read_data),
    .B_reg_read_valid (B_reg_read_valid),
    .B_reg_read_data  (B_reg_read_data),
    .WB_valid         (WB_valid),
    .WB_data          (WB_data),
    .WB_PR            (WB_PR),
    .WB_ready         (WB_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a + b;
      4'b1000: return a + ~b + 32'd1;
      4'b0001: return a << sh;
      4'b0010: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'b0011: return {31'd0, a < b};
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_idle();
    issue_valid      = 1'b0;
    issue_op         = 4'd0;
    issue_is_imm     = 1'b0;
    issue_imm        = 32'd0;
    issue_A_unneeded = 1'b0;
    issue_A_forward  = 1'b0;
    issue_A_bank     = 2'd0;
    issue_B_forward  = 1'b0;
    issue_B_bank     = 2'd0;
    issue_dest_PR    = '0;
    WB_data_by_bank  = '0;
    A_reg_read_valid = 1'b0;
    A_reg_read_data  = 32'd0;
    B_reg_read_valid = 1'b0;
    B_reg_read_data  = 32'd0;
  endtask

  // Called at a negedge; returns at the negedge after the op was accepted.
  task automatic issue(input logic [3:0] op, input logic a_unn, input logic a_fwd, input logic [1:0] a_bank,
                       input logic [31:0] a_dat, input logic is_imm, input logic b_fwd, input logic [1:0] b_bank,
                       input logic [31:0] b_dat, input logic [PRW-1:0] dest, input logic [31:0] exp_data);
    bit done;
    done             = 1'b0;
    issue_valid      = 1'b1;
    issue_op         = op;
    issue_A_unneeded = a_unn;
    issue_A_forward  = a_fwd;
    issue_A_bank     = a_bank;
    issue_is_imm     = is_imm;
    issue_imm        = b_dat;
    issue_B_forward  = b_fwd;
    issue_B_bank     = b_bank;
    issue_dest_PR    = dest;
    if (a_fwd) WB_data_by_bank[a_bank] = a_dat;
    if (b_fwd) WB_data_by_bank[b_bank] = b_dat;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (issue_ready) begin
        exp_q.push_back('{data: exp_data, pr: dest});
        n_acc++;
        done = 1'b1;
      end
      @(negedge CLK);
    end
    issue_valid = 1'b0;
    check("issue_accept", 32'(done), 32'd1);
  endtask

  task automatic fwd_imm(input logic [3:0] op, input logic [31:0] a, input logic [31:0] imm,
                         input logic [PRW-1:0] dest, input logic [31:0] exp_data);
    issue(op, 1'b0, 1'b1, 2'd0, a, 1'b1, 1'b0, 2'd0, imm, dest, exp_data);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge CLK);
    repeat (2) @(negedge CLK);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: pops on each WB transfer and checks that a stalled result stays put.
  initial begin
    exp_t           e;
    logic           hold;
    logic [31:0]    hd;
    logic [PRW-1:0] hp;
    hold = 1'b0;
    hd   = '0;
    hp   = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (RST) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("wb_hold_valid", 32'(WB_valid), 32'd1);
          check("wb_hold_data", WB_data, hd);
          check("wb_hold_pr", 32'(WB_PR), 32'(hp));
        end
        hold = WB_valid & ~WB_ready;
        hd   = WB_data;
        hp   = WB_PR;
        if (WB_valid && WB_ready) begin
          n_wb++;
          if (exp_q.size() == 0) begin
            check("wb_unexpected", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("wb_data", WB_data, e.data);
            check("wb_pr", 32'(WB_PR), 32'(e.pr));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, wbase;
    set_idle();
    WB_ready = 1'b1;
    RST      = 1'b1;
    rand_done = 1'b0;

    // Reset behaviour, during and the cycle after
    repeat (3) @(negedge CLK);
    #1;
    check("rst_wb_valid", 32'(WB_valid), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_wb_data", WB_data, 32'd0);
    check("rst_wb_pr", 32'(WB_PR), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("post_rst_wb_valid", 32'(WB_valid), 32'd0);
    check("post_rst_issue_ready", 32'(issue_ready), 32'd1);
    check("post_rst_wb_data", WB_data, 32'd0);
    check("post_rst_wb_pr", 32'(WB_PR), 32'd0);
    @(negedge CLK);

    // ADD imm with forwarded A: WB exactly at N+3
    issue(ALU_ADD, 1'b0, 1'b1, 2'd2, 32'd5, 1'b1, 1'b0, 2'd0, 32'd7, 6'd9, 32'd12);
    #1 check("add_lat_n1", 32'(WB_valid), 32'd0);
    @(negedge CLK);
    #1 check("add_lat_n2", 32'(WB_valid), 32'd0);
    @(negedge CLK);
    #1;
    check("add_lat_n3_valid", 32'(WB_valid), 32'd1);
    check("add_lat_n3_data", WB_data, 32'd12);
    check("add_lat_n3_pr", 32'(WB_PR), 32'd9);
    @(negedge CLK);
    drain();

    // Late operands: A at N+1, B at N+4, result at N+6
    issue(ALU_SUB, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 6'd11, 32'd7);
    A_reg_read_valid = 1'b1;
    A_reg_read_data  = 32'd10;
    #1 check("late_ready_n1", 32'(issue_ready), 32'd0);
    @(negedge CLK);
    A_reg_read_valid = 1'b0;
    #1 check("late_ready_n2", 32'(issue_ready), 32'd0);
    @(negedge CLK);
    #1 check("late_ready_n3", 32'(issue_ready), 32'd0);
    @(negedge CLK);
    B_reg_read_valid = 1'b1;
    B_reg_read_data  = 32'd3;
    #1 check("late_ready_n4", 32'(issue_ready), 32'd1);
    @(negedge CLK);
    B_reg_read_valid = 1'b0;
    #1 check("late_wb_n5", 32'(WB_valid), 32'd0);
    @(negedge CLK);
    #1;
    check("late_wb_n6_valid", 32'(WB_valid), 32'd1);
    check("late_wb_n6_data", WB_data, 32'd7);
    @(negedge CLK);
    drain();

    // Both responses in the same cycle
    issue(ALU_SUB, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 6'd12, 32'd42);
    A_reg_read_valid = 1'b1;
    A_reg_read_data  = 32'd50;
    B_reg_read_valid = 1'b1;
    B_reg_read_data  = 32'd8;
    #1 check("both_resp_ready", 32'(issue_ready), 32'd1);
    @(negedge CLK);
    A_reg_read_valid = 1'b0;
    B_reg_read_valid = 1'b0;
    drain();

    // Stray responses with OC empty, then a response during the issue cycle itself
    A_reg_read_valid = 1'b1;
    A_reg_read_data  = 32'hDEAD;
    B_reg_read_valid = 1'b1;
    B_reg_read_data  = 32'hBEEF;
    #1;
    check("stray_ready", 32'(issue_ready), 32'd1);
    check("stray_wb_valid", 32'(WB_valid), 32'd0);
    @(negedge CLK);
    A_reg_read_valid = 1'b0;
    B_reg_read_valid = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("stray_after_ready", 32'(issue_ready), 32'd1);
    check("stray_after_wb", 32'(WB_valid), 32'd0);
    @(negedge CLK);
    A_reg_read_valid = 1'b1;
    A_reg_read_data  = 32'd99;
    issue(ALU_ADD, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd0, 32'd5, 6'd13, 32'd25);
    A_reg_read_data = 32'd20;
    @(negedge CLK);
    A_reg_read_valid = 1'b0;
    drain();

    // Op coverage, back to back
    fwd_imm(ALU_SRA, 32'h8000_0000, 32'd4, 6'd1, 32'hF800_0000);
    issue(ALU_SLT, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'd1, 32'd1, 6'd2, 32'd1);
    issue(ALU_SLTU, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'd1, 32'd1, 6'd3, 32'd0);
    fwd_imm(4'b1001, 32'h1234_5678, 32'd3, 6'd4, 32'd0);
    issue(ALU_ADD, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 2'd0, 32'h1000, 6'd5, 32'h1000);
    fwd_imm(ALU_SLL, 32'd1, 32'd31, 6'd6, 32'h8000_0000);
    fwd_imm(ALU_SLL, 32'd1, 32'd33, 6'd7, 32'd2);
    fwd_imm(ALU_SRL, 32'h8000_0000, 32'd31, 6'd8, 32'd1);
    fwd_imm(ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 6'd10, 32'h0FF0_0FF0);
    fwd_imm(ALU_OR, 32'h0F0F_0000, 32'h0000_00F0, 6'd14, 32'h0F0F_00F0);
    fwd_imm(ALU_AND, 32'hFFFF_0000, 32'h1234_5678, 6'd15, 32'h1234_0000);
    fwd_imm(ALU_SUB, 32'd0, 32'd1, 6'd16, 32'hFFFF_FFFF);
    fwd_imm(ALU_ADD, 32'hFFFF_FFFF, 32'd2, 6'd17, 32'd1);
    drain();

    // Backpressure: 3 accepted while WB is stalled, then all 4 retire in order
    WB_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int k = 0; k < 4; k++)
          issue(ALU_ADD, 1'b0, 1'b1, 2'd3, 32'(100 + k), 1'b1, 1'b0, 2'd0, 32'(k), 6'(20 + k), 32'(100 + 2 * k));
      end
      begin
        repeat (6) @(negedge CLK);
        #1;
        check("bp_accepted", 32'(n_acc - base), 32'd3);
        check("bp_issue_ready", 32'(issue_ready), 32'd0);
        @(negedge CLK);
        WB_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight: they must never write back
    WB_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      fwd_imm(ALU_ADD, 32'(k), 32'd1, 6'(30 + k), 32'(k + 1));
    RST = 1'b1;
    exp_q.delete();
    wbase = n_wb;
    #1;
    check("midrst_wb_valid", 32'(WB_valid), 32'd0);
    check("midrst_issue_ready", 32'(issue_ready), 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("midrst_after_wb_valid", 32'(WB_valid), 32'd0);
    check("midrst_after_ready", 32'(issue_ready), 32'd1);
    check("midrst_after_data", WB_data, 32'd0);
    check("midrst_after_pr", 32'(WB_PR), 32'd0);
    @(negedge CLK);
    WB_ready = 1'b1;
    repeat (8) @(negedge CLK);
    check("midrst_no_wb", 32'(n_wb), 32'(wbase));

    // Random traffic with random WB backpressure
    fork
      begin
        logic [3:0] ops[12];
        logic [3:0] op;
        logic [31:0] a, b;
        logic [1:0] ab;
        logic a_unn, imm;
        ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001, 4'b1111};
        for (int k = 0; k < 60; k++) begin
          op    = ops[$urandom_range(0, 11)];
          a     = $urandom;
          b     = $urandom;
          ab    = 2'($urandom_range(0, 3));
          a_unn = ($urandom_range(0, 7) == 0);
          imm   = $urandom_range(0, 1);
          issue(op, a_unn, 1'b1, ab, a, imm, ~imm, ab + 2'd1, b, 6'($urandom),
                ref_alu(op, a_unn ? 32'd0 : a, b));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge CLK);
          WB_ready = $urandom_range(0, 1);
        end
        WB_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
